// File: rtl/logic_op_identifier_pkg.sv
// Shared definitions for the logic-unit identifier: op codes, FSM states,
// and the one-hot/index helpers used when a single candidate survives.
package logic_op_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_NAND = 2'b10;
    localparam logic [1:0] OP_NOR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } state_t;

    // True when exactly one bit of the candidate mask is set.
    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    // Index of the set bit of a one-hot mask (undefined input -> 0).
    function automatic logic [1:0] oh2idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'b00;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) idx = i[1:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/logic_op_identifier_if.sv
// Observation sample stream: one (a, b, result) triple per valid/ready beat.
interface logic_op_identifier_if;
    logic in_valid;
    logic in_ready;
    logic a;
    logic b;
    logic result;

    modport master (output in_valid, a, b, result, input in_ready);
    modport slave  (input in_valid, a, b, result, output in_ready);
endinterface

// File: rtl/logic_op_identifier_check.sv
// Combinational consistency check: which of the four ops could have produced
// this (a, b, result) triple. Bit i of ok corresponds to op code i.
module logic_op_check
    import logic_op_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       result,
    output logic [3:0] ok
);
    // One comparison per candidate operation.
    always_comb begin
        ok          = 4'b0000;
        ok[OP_AND]  = (result == (a & b));
        ok[OP_OR]   = (result == (a | b));
        ok[OP_NAND] = (result == ~(a & b));
        ok[OP_NOR]  = (result == ~(a | b));
    end
endmodule

// File: rtl/logic_op_identifier.sv
// Sequential identifier for the AND/OR/NAND/NOR logic unit. Each accepted
// sample removes inconsistent candidates; resolves to DONE with the select
// code, or ERR on contradiction or when the sample limit is reached.
module logic_op_identifier
    import logic_op_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    logic_op_identifier_if.slave     smp,
    output logic [1:0]               sel_out,
    output logic [3:0]               cand_mask,
    output logic                     found,
    output logic                     error,
    output logic                     timeout,
    output logic                     busy,
    output logic [CNT_W-1:0]         sample_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [3:0]       ok;
    logic [3:0]       nmask;
    logic [CNT_W-1:0] ncnt;
    logic             hs;

    logic_op_check u_check (
        .a      (smp.a),
        .b      (smp.b),
        .result (smp.result),
        .ok     (ok)
    );

    // Ready is decoded straight from state so it drops with found/error.
    assign smp.in_ready = (state == ST_RUN);

    // A sample coinciding with start/abort is dropped even though ready was high.
    assign hs = smp.in_valid && smp.in_ready && !start && !abort;

    // Next mask and saturating next count for the current sample.
    always_comb begin
        nmask = cand_mask & ok;
        ncnt  = (sample_cnt == CNT_MAX) ? sample_cnt : sample_cnt + 1'b1;
    end

    // Identification FSM with registered outputs; abort beats start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cand_mask  <= 4'b0000;
            sel_out    <= 2'b00;
            sample_cnt <= '0;
            found      <= 1'b0;
            error      <= 1'b0;
            timeout    <= 1'b0;
            busy       <= 1'b0;
        end else if (abort) begin
            state      <= ST_IDLE;
            cand_mask  <= 4'b0000;
            sel_out    <= 2'b00;
            sample_cnt <= '0;
            found      <= 1'b0;
            error      <= 1'b0;
            timeout    <= 1'b0;
            busy       <= 1'b0;
        end else if (start) begin
            state      <= ST_RUN;
            cand_mask  <= 4'b1111;
            sel_out    <= 2'b00;
            sample_cnt <= '0;
            found      <= 1'b0;
            error      <= 1'b0;
            timeout    <= 1'b0;
            busy       <= 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    if (hs) begin
                        cand_mask  <= nmask;
                        sample_cnt <= ncnt;
                        if (is_onehot(nmask)) begin
                            state   <= ST_DONE;
                            found   <= 1'b1;
                            sel_out <= oh2idx(nmask);
                            busy    <= 1'b0;
                        end else if (nmask == 4'b0000) begin
                            state <= ST_ERR;
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end else if (ncnt == CNT_MAX) begin
                            state   <= ST_ERR;
                            error   <= 1'b1;
                            timeout <= 1'b1;
                            busy    <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_op_identifier.sv
// Randomised bench for logic_op_identifier: two instances (CNT_W=4 and 2)
// see identical stimulus and are compared every cycle against a reference
// model that evaluates the four logic functions directly.
module tb_logic_op_identifier;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;

    logic_op_identifier_if if0 ();
    logic_op_identifier_if if1 ();

    logic [1:0][1:0] sel_o;
    logic [1:0][3:0] mask_o;
    logic [1:0]      found_o, error_o, tmo_o, busy_o, rdy_o;
    logic [3:0]      cnt0;
    logic [1:0]      cnt1;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state, one slot per instance. st: 0 idle, 1 run, 2 done, 3 err.
    int         m_st[2];
    logic [3:0] m_mask[2];
    int         m_cnt[2];
    logic [1:0] m_sel[2];
    bit         m_found[2], m_err[2], m_tmo[2];
    int         lim[2] = '{15, 3};
    int         hidden = 0;

    always #5 clk = ~clk;

    logic_op_identifier #(.CNT_W(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .smp(if0.slave),
        .sel_out(sel_o[0]), .cand_mask(mask_o[0]), .found(found_o[0]), .error(error_o[0]),
        .timeout(tmo_o[0]), .busy(busy_o[0]), .sample_cnt(cnt0)
    );

    logic_op_identifier #(.CNT_W(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .smp(if1.slave),
        .sel_out(sel_o[1]), .cand_mask(mask_o[1]), .found(found_o[1]), .error(error_o[1]),
        .timeout(tmo_o[1]), .busy(busy_o[1]), .sample_cnt(cnt1)
    );

    assign rdy_o[0] = if0.in_ready;
    assign rdy_o[1] = if1.in_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit op_eval(input int code, input bit a, input bit b);
        case (code)
            0:       return a & b;
            1:       return a | b;
            2:       return !(a & b);
            default: return !(a | b);
        endcase
    endfunction

    function automatic void model_clear(input int i);
        m_st[i] = 0; m_mask[i] = 4'b0000; m_cnt[i] = 0; m_sel[i] = 2'b00;
        m_found[i] = 0; m_err[i] = 0; m_tmo[i] = 0;
    endfunction

    function automatic void model_step(input int i, input bit st, input bit ab,
                                       input bit v, input bit a, input bit b, input bit r);
        int n;
        int last;
        if (ab) model_clear(i);
        else if (st) begin
            model_clear(i);
            m_st[i] = 1; m_mask[i] = 4'b1111;
        end else if (m_st[i] == 1 && v) begin
            n = 0; last = 0;
            for (int k = 0; k < 4; k++) begin
                if (m_mask[i][k] && op_eval(k, a, b) != r) m_mask[i][k] = 1'b0;
                if (m_mask[i][k]) begin n++; last = k; end
            end
            m_cnt[i]++;
            if (n == 1) begin
                m_st[i] = 2; m_found[i] = 1; m_sel[i] = 2'(last);
            end else if (n == 0) begin
                m_st[i] = 3; m_err[i] = 1;
            end else if (m_cnt[i] == lim[i]) begin
                m_st[i] = 3; m_err[i] = 1; m_tmo[i] = 1;
            end
        end
    endfunction

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("d%0d.cand_mask", i), 32'(mask_o[i]), 32'(m_mask[i]));
            chk($sformatf("d%0d.sel_out", i), 32'(sel_o[i]), 32'(m_sel[i]));
            chk($sformatf("d%0d.found", i), 32'(found_o[i]), 32'(m_found[i]));
            chk($sformatf("d%0d.error", i), 32'(error_o[i]), 32'(m_err[i]));
            chk($sformatf("d%0d.timeout", i), 32'(tmo_o[i]), 32'(m_tmo[i]));
            chk($sformatf("d%0d.busy", i), 32'(busy_o[i]), 32'(m_st[i] == 1));
            chk($sformatf("d%0d.in_ready", i), 32'(rdy_o[i]), 32'(m_st[i] == 1));
        end
        chk("d0.sample_cnt", 32'(cnt0), 32'(m_cnt[0]));
        chk("d1.sample_cnt", 32'(cnt1), 32'(m_cnt[1]));
    endtask

    // Drive one cycle of stimulus, clock it, advance the model, compare.
    task automatic step(input bit st, input bit ab, input bit v,
                        input bit a, input bit b, input bit r);
        start = st; abort = ab;
        if0.in_valid = v; if0.a = a; if0.b = b; if0.result = r;
        if1.in_valid = v; if1.a = a; if1.b = b; if1.result = r;
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i, st, ab, v, a, b, r);
        #1;
        check_all();
    endtask

    initial begin
        bit st, ab, v, a, b, r;
        if0.in_valid = 0; if0.a = 0; if0.b = 0; if0.result = 0;
        if1.in_valid = 0; if1.a = 0; if1.b = 0; if1.result = 0;
        model_clear(0); model_clear(1);
        #3;
        check_all();
        @(negedge clk) rst_n = 1'b1;

        // AND/OR ambiguous, then OR resolves.
        step(1, 0, 0, 0, 0, 0);
        chk("t1.ready_after_start", 32'(rdy_o[0]), 32'd1);
        step(0, 0, 1, 1, 1, 1);
        chk("t1.mask1", 32'(mask_o[0]), 32'b0011);
        step(0, 0, 1, 0, 1, 1);
        chk("t1.mask2", 32'(mask_o[0]), 32'b0010);
        chk("t1.found", 32'(found_o[0]), 32'd1);
        chk("t1.sel", 32'(sel_o[0]), 32'b01);
        chk("t1.cnt", 32'(cnt0), 32'd2);
        chk("t1.ready_drop", 32'(rdy_o[0]), 32'd0);

        // NAND resolves.
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 1);
        chk("t2.mask1", 32'(mask_o[0]), 32'b1100);
        step(0, 0, 1, 1, 0, 1);
        chk("t2.mask2", 32'(mask_o[0]), 32'b0100);
        chk("t2.sel", 32'(sel_o[0]), 32'b10);

        // Contradiction.
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 1);
        step(0, 0, 1, 1, 1, 1);
        chk("t3.mask", 32'(mask_o[0]), 32'b0000);
        chk("t3.error", 32'(error_o[0]), 32'd1);
        chk("t3.timeout", 32'(tmo_o[0]), 32'd0);
        chk("t3.found", 32'(found_o[0]), 32'd0);

        // Timeout on the narrow counter.
        step(1, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 1, 0, 0, 0);
        chk("t4.mask", 32'(mask_o[1]), 32'b0011);
        chk("t4.error", 32'(error_o[1]), 32'd1);
        chk("t4.timeout", 32'(tmo_o[1]), 32'd1);
        chk("t4.cnt", 32'(cnt1), 32'd3);
        chk("t4.wide_busy", 32'(busy_o[0]), 32'd1);

        // Sample with start is discarded.
        step(1, 0, 1, 1, 1, 0);
        step(0, 0, 1, 1, 1, 0);
        chk("t5.mask", 32'(mask_o[0]), 32'b1100);
        chk("t5.cnt", 32'(cnt0), 32'd1);

        // Async reset mid-run.
        #2 rst_n = 1'b0;
        model_clear(0); model_clear(1);
        #1;
        check_all();
        chk("t6.busy", 32'(busy_o[0]), 32'd0);
        @(posedge clk); #1;
        check_all();
        rst_n = 1'b1;

        // Abort with start in DONE.
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 1, 1);
        step(0, 0, 1, 0, 1, 1);
        step(1, 1, 1, 1, 1, 1);
        chk("t7.found", 32'(found_o[0]), 32'd0);
        chk("t7.ready", 32'(rdy_o[0]), 32'd0);

        // Random traffic biased toward consistent samples so timeouts occur.
        for (int n = 0; n < 3000; n++) begin
            st = ($urandom_range(0, 15) == 0);
            ab = ($urandom_range(0, 39) == 0);
            if (st) hidden = $urandom_range(0, 3);
            v = $urandom_range(0, 1);
            a = $urandom_range(0, 1);
            b = ($urandom_range(0, 1) == 0) ? a : bit'($urandom_range(0, 1));
            r = ($urandom_range(0, 9) < 8) ? op_eval(hidden, a, b) : bit'($urandom_range(0, 1));
            step(st, ab, v, a, b, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
